kronos_dmem_ctrl: RTL and testbench

Data-memory controller sitting directly downstream of the Kronos load/store unit. It services the LSU's word-aligned req/ack data interface against a single-port synchronous SRAM with byte write-enables. It adds configurable wait states and flags accesses that fall outside its address window. One transaction is in flight at a time, with fixed, deterministic latency.

---
 rtl/kronos_dmem_ctrl.sv | 166 ++++++++++++++++
 tb/tb_kronos_dmem_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kronos_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// kronos_dmem_ctrl
//
// Data-memory controller placed directly after the Kronos load/store unit.
// It turns the LSU's word-aligned req/ack data interface into accesses on a
// single-port synchronous SRAM with byte write-enables. It also inserts a
// configurable number of wait states and flags accesses outside the address
// window. Only one transaction is in flight, and latency is fixed.
//
// Handshake (req/ack):
//   The LSU raises data_req and keeps it and the request fields stable until
//   it sees data_ack=1. The controller samples a request only in IDLE. It
//   acknowledges with exactly one data_ack pulse exactly 3+WAIT_STATES cycles
//   after the sampling cycle. data_rd_data and bus_err are meaningful only
//   while data_ack=1 and read 0 otherwise. A data_req still high in the cycle
//   after the ack is treated as a new request.
//
// Parameters:
//   ADDR_WIDTH  - SRAM word-address width; window = 4*2**ADDR_WIDTH bytes
//   BASE_ADDR   - window base, aligned to the window size
//   WAIT_STATES - extra cycles (0..15) inserted before the ack
//
// Ports:
//   clk, rstz      - clock; asynchronous active-low reset
//   data_addr      - request byte address (bits [1:0] ignored)
//   data_wr_data   - store data, already lane-rotated by the LSU
//   data_wr_mask   - byte write enables (bit i = lane i)
//   data_wr_en     - 1 = write, 0 = read
//   data_req       - request, held until acked
//   data_ack       - one-cycle completion pulse
//   data_rd_data   - read data, valid while data_ack=1
//   bus_err        - out-of-window flag, pulses with data_ack
//   sram_*         - SRAM command outputs / read data input
//   dbg_state      - current FSM state, for observation only
// -----------------------------------------------------------------------------
module kronos_dmem_ctrl #(
    parameter int          ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rstz,
    input  logic [31:0]           data_addr,
    input  logic [31:0]           data_wr_data,
    input  logic [3:0]            data_wr_mask,
    input  logic                  data_wr_en,
    input  logic                  data_req,
    output logic                  data_ack,
    output logic [31:0]           data_rd_data,
    output logic                  bus_err,
    output logic                  sram_cs,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [3:0]            sram_wmask,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata,
    output logic [2:0]            dbg_state
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ACCESS  = 3'd1;
    localparam logic [2:0] CAPTURE = 3'd2;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] RESP    = 3'd4;

    localparam logic [3:0] WS_LAST = 4'(WAIT_STATES);

    logic [2:0]            r_state;
    logic [3:0]            r_wcnt;
    logic                  r_we;
    logic                  r_in_win;
    logic [31:0]           r_capture;
    logic                  r_sram_cs;
    logic                  r_sram_we;
    logic [ADDR_WIDTH-1:0] r_sram_addr;
    logic [3:0]            r_sram_wmask;
    logic [31:0]           r_sram_wdata;

    logic w_in_win;
    logic w_resp;
    logic w_unused_addr_lsbs;

    // Window check compares only the bits above the window offset.
    assign w_in_win = (data_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);

    // Word-aligned interface: the byte offset carries no information here.
    assign w_unused_addr_lsbs = ^data_addr[1:0];

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_state      <= IDLE;
            r_wcnt       <= 4'd0;
            r_we         <= 1'b0;
            r_in_win     <= 1'b0;
            r_capture    <= 32'h0;
            r_sram_cs    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wmask <= 4'h0;
            r_sram_wdata <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (data_req) begin
                        // The request is latched here. From this point on,
                        // the LSU-side inputs are ignored until the next IDLE.
                        r_we         <= data_wr_en;
                        r_in_win     <= w_in_win;
                        r_sram_cs    <= w_in_win;
                        r_sram_we    <= w_in_win & data_wr_en;
                        r_sram_addr  <= data_addr[ADDR_WIDTH+1:2];
                        r_sram_wmask <= (w_in_win && data_wr_en) ? data_wr_mask : 4'h0;
                        r_sram_wdata <= data_wr_data;
                        r_state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_sram_cs    <= 1'b0;
                    r_sram_we    <= 1'b0;
                    r_sram_wmask <= 4'h0;
                    r_state      <= CAPTURE;
                end
                CAPTURE: begin
                    // SRAM read data is valid in the cycle after the chip select.
                    r_capture <= (r_in_win && !r_we) ? sram_rdata : 32'h0;
                    if (WAIT_STATES > 0) begin
                        r_wcnt  <= 4'd1;
                        r_state <= ST_WAIT;
                    end else begin
                        r_state <= RESP;
                    end
                end
                ST_WAIT: begin
                    if (r_wcnt == WS_LAST) begin
                        r_wcnt  <= 4'd0;
                        r_state <= RESP;
                    end else begin
                        r_wcnt <= r_wcnt + 4'd1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // The response outputs are decoded from registers only. Because of that,
    // they drop to 0 as soon as RESP is left or reset is asserted.
    assign w_resp       = (r_state == RESP);
    assign data_ack     = w_resp;
    assign data_rd_data = w_resp ? r_capture : 32'h0;
    assign bus_err      = w_resp & ~r_in_win;

    assign sram_cs    = r_sram_cs;
    assign sram_we    = r_sram_we;
    assign sram_addr  = r_sram_addr;
    assign sram_wmask = r_sram_wmask;
    assign sram_wdata = r_sram_wdata;

    assign dbg_state  = r_state;

endmodule

// File: tb/tb_kronos_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_kronos_dmem_ctrl
//
// Two controller instances share one clock. Instance 0 uses WAIT_STATES=0 and
// instance 1 uses WAIT_STATES=3. Each instance has its own behavioural SRAM.
//
// The bench keeps a transaction-level model. When a request is issued, it
// computes the ack cycle (issue cycle + 3 + wait states) and the chip-select
// cycle. It also computes the returned data from a reference memory image and
// the bus error from the window rule. One compare process checks both
// instances every cycle on the falling edge. Literal expectations from the
// directed scenarios pin the model itself.
// -----------------------------------------------------------------------------
module tb_kronos_dmem_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rstz         [2];
    logic [31:0] data_addr    [2];
    logic [31:0] data_wr_data [2];
    logic [3:0]  data_wr_mask [2];
    logic        data_wr_en   [2];
    logic        data_req     [2];
    logic        data_ack     [2];
    logic [31:0] data_rd_data [2];
    logic        bus_err      [2];
    logic        sram_cs      [2];
    logic        sram_we      [2];
    logic [11:0] sram_addr    [2];
    logic [3:0]  sram_wmask   [2];
    logic [31:0] sram_wdata   [2];
    logic [31:0] sram_rdata   [2];
    logic [2:0]  dbg_state    [2];

    kronos_dmem_ctrl #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rstz(rstz[0]),
        .data_addr(data_addr[0]), .data_wr_data(data_wr_data[0]),
        .data_wr_mask(data_wr_mask[0]), .data_wr_en(data_wr_en[0]),
        .data_req(data_req[0]), .data_ack(data_ack[0]),
        .data_rd_data(data_rd_data[0]), .bus_err(bus_err[0]),
        .sram_cs(sram_cs[0]), .sram_we(sram_we[0]), .sram_addr(sram_addr[0]),
        .sram_wmask(sram_wmask[0]), .sram_wdata(sram_wdata[0]),
        .sram_rdata(sram_rdata[0]), .dbg_state(dbg_state[0])
    );

    kronos_dmem_ctrl #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .rstz(rstz[1]),
        .data_addr(data_addr[1]), .data_wr_data(data_wr_data[1]),
        .data_wr_mask(data_wr_mask[1]), .data_wr_en(data_wr_en[1]),
        .data_req(data_req[1]), .data_ack(data_ack[1]),
        .data_rd_data(data_rd_data[1]), .bus_err(bus_err[1]),
        .sram_cs(sram_cs[1]), .sram_we(sram_we[1]), .sram_addr(sram_addr[1]),
        .sram_wmask(sram_wmask[1]), .sram_wdata(sram_wdata[1]),
        .sram_rdata(sram_rdata[1]), .dbg_state(dbg_state[1])
    );

    // ---------------- behavioural SRAMs ----------------
    logic [31:0] mem     [2][4096];
    logic [31:0] ref_mem [2][4096];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (sram_cs[k]) begin
                if (sram_we[k]) begin
                    for (int b = 0; b < 4; b++)
                        if (sram_wmask[k][b]) mem[k][sram_addr[k]][8*b +: 8] <= sram_wdata[k][8*b +: 8];
                end else begin
                    sram_rdata[k] <= mem[k][sram_addr[k]];
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          idx;
        int          ack_cyc;
        int          cs_cyc;
        logic [11:0] addr;
        logic        we;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    int          ack_cnt      [2];
    int          cs_cnt       [2];
    int          last_ack_cyc [2];
    logic [31:0] last_rd      [2];
    logic        last_err     [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int ws(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    // Compare process: every cycle, on the falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rstz[k]) begin
                chk("rst_ack",   32'(data_ack[k]), 32'h0);
                chk("rst_rd",    data_rd_data[k],  32'h0);
                chk("rst_err",   32'(bus_err[k]),  32'h0);
                chk("rst_cs",    32'(sram_cs[k]),  32'h0);
                chk("rst_we",    32'(sram_we[k]),  32'h0);
                chk("rst_addr",  32'(sram_addr[k]), 32'h0);
                chk("rst_wmask", 32'(sram_wmask[k]), 32'h0);
                chk("rst_wdata", sram_wdata[k],    32'h0);
            end else begin
                logic e_ack, e_cs;
                e_ack = (exp_q.size() > 0) && (exp_q[0].idx == k) && (exp_q[0].ack_cyc == cyc);
                e_cs  = (exp_q.size() > 0) && (exp_q[0].idx == k) && (exp_q[0].cs_cyc == cyc);
                chk("ack", 32'(data_ack[k]), 32'(e_ack));
                chk("rd_data", data_rd_data[k], e_ack ? exp_q[0].rd : 32'h0);
                chk("bus_err", 32'(bus_err[k]), e_ack ? 32'(exp_q[0].err) : 32'h0);
                chk("sram_cs", 32'(sram_cs[k]), 32'(e_cs));
                if (e_cs) begin
                    chk("sram_addr",  32'(sram_addr[k]),  32'(exp_q[0].addr));
                    chk("sram_we",    32'(sram_we[k]),    32'(exp_q[0].we));
                    chk("sram_wmask", 32'(sram_wmask[k]), exp_q[0].we ? 32'(exp_q[0].mask) : 32'h0);
                    if (exp_q[0].we) chk("sram_wdata", sram_wdata[k], exp_q[0].wdata);
                end
            end
            if (data_ack[k]) begin
                ack_cnt[k]++;
                last_ack_cyc[k] = cyc;
                last_rd[k]      = data_rd_data[k];
                last_err[k]     = bus_err[k];
            end
            if (sram_cs[k]) cs_cnt[k]++;
        end
        if (exp_q.size() > 0 && exp_q[0].ack_cyc <= cyc) void'(exp_q.pop_front());
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; the current cycle is the request cycle T.
    task automatic issue(input int k, input logic [31:0] a, input logic we,
                         input logic [3:0] m, input logic [31:0] d);
        exp_t e;
        logic inw;
        int   w;
        inw = (a[31:14] == 18'h0);
        w   = int'(a[13:2]);
        data_addr[k] = a; data_wr_en[k] = we; data_wr_mask[k] = m;
        data_wr_data[k] = d; data_req[k] = 1'b1;
        e.idx = k; e.ack_cyc = cyc + 3 + ws(k); e.cs_cyc = inw ? cyc + 1 : -1;
        e.addr = a[13:2]; e.we = we; e.mask = m; e.wdata = d;
        e.err = ~inw; e.rd = 32'h0;
        if (inw && we) begin
            for (int b = 0; b < 4; b++)
                if (m[b]) ref_mem[k][w][8*b +: 8] = d[8*b +: 8];
        end else if (inw) begin
            e.rd = ref_mem[k][w];
        end
        exp_q.push_back(e);
    endtask

    // Advance past the ack edge; a fixed cycle budget, never an open wait.
    task automatic wait_done(input int k);
        repeat (4 + ws(k)) @(posedge clk);
        #1;
    endtask

    task automatic drop(input int k);
        data_req[k] = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    int t0, t1, a0, c0;

    initial begin
        for (int k = 0; k < 2; k++) begin
            rstz[k] = 1'b0; data_addr[k] = 32'h0; data_wr_data[k] = 32'h0;
            data_wr_mask[k] = 4'h0; data_wr_en[k] = 1'b0; data_req[k] = 1'b0;
            sram_rdata[k] = 32'h0;
            ack_cnt[k] = 0; cs_cnt[k] = 0; last_ack_cyc[k] = -1;
            last_rd[k] = 32'h0; last_err[k] = 1'b0;
            for (int i = 0; i < 4096; i++) begin
                mem[k][i]     = 32'h1000_0000 + 32'(i);
                ref_mem[k][i] = 32'h1000_0000 + 32'(i);
            end
        end
        mem[0][5] = 32'hDEAD_BEEF; ref_mem[0][5] = 32'hDEAD_BEEF;
        mem[0][0] = 32'hCAFE_F00D; ref_mem[0][0] = 32'hCAFE_F00D;
        mem[1][7] = 32'h1234_5678; ref_mem[1][7] = 32'h1234_5678;

        step(3);
        rstz[0] = 1'b1; rstz[1] = 1'b1;
        step(2);

        // 1: aligned read of word 5
        t0 = cyc; issue(0, 32'h14, 1'b0, 4'h0, 32'h0); wait_done(0); drop(0);
        chk("t1_ack_cyc", 32'(last_ack_cyc[0]), 32'(t0 + 3));
        chk("t1_rd",      last_rd[0], 32'hDEAD_BEEF);
        chk("t1_err",     32'(last_err[0]), 32'h0);
        step(1);

        // 2: byte-lane write into word 5
        t0 = cyc; issue(0, 32'h14, 1'b1, 4'b0010, 32'h0000_AB00); wait_done(0); drop(0);
        chk("t2_ack_cyc", 32'(last_ack_cyc[0]), 32'(t0 + 3));
        chk("t2_rd",      last_rd[0], 32'h0);
        chk("t2_mem",     mem[0][5], 32'hDEAD_ABEF);
        step(1);

        // 3: back-to-back pair with req held across the ack edge
        a0 = ack_cnt[0]; c0 = cs_cnt[0];
        t0 = cyc; issue(0, 32'h14, 1'b0, 4'h0, 32'h0); wait_done(0);
        t1 = cyc; issue(0, 32'h18, 1'b0, 4'h0, 32'h0); wait_done(0); drop(0);
        chk("t3_t1",        32'(t1), 32'(t0 + 4));
        chk("t3_ack_cyc",   32'(last_ack_cyc[0]), 32'(t0 + 7));
        chk("t3_rd",        last_rd[0], 32'h1000_0006);
        chk("t3_acks",      32'(ack_cnt[0] - a0), 32'd2);
        chk("t3_cs_pulses", 32'(cs_cnt[0] - c0), 32'd2);
        step(2);

        // 4: three wait states on instance 1
        t0 = cyc; issue(1, 32'h1C, 1'b0, 4'h0, 32'h0); wait_done(1); drop(1);
        chk("t4_ack_cyc", 32'(last_ack_cyc[1]), 32'(t0 + 6));
        chk("t4_rd",      last_rd[1], 32'h1234_5678);
        step(1);
        t0 = cyc; issue(1, 32'h1C, 1'b1, 4'b1001, 32'hAA00_00BB); wait_done(1); drop(1);
        chk("t4w_ack_cyc", 32'(last_ack_cyc[1]), 32'(t0 + 6));
        chk("t4w_mem",     mem[1][7], 32'hAA34_56BB);
        step(1);

        // 5: out-of-window write never reaches the SRAM
        c0 = cs_cnt[0];
        t0 = cyc; issue(0, 32'h0000_4000, 1'b1, 4'hF, 32'h5555_5555); wait_done(0); drop(0);
        chk("t5_ack_cyc", 32'(last_ack_cyc[0]), 32'(t0 + 3));
        chk("t5_err",     32'(last_err[0]), 32'h1);
        chk("t5_rd",      last_rd[0], 32'h0);
        chk("t5_cs",      32'(cs_cnt[0] - c0), 32'd0);
        chk("t5_mem",     mem[0][0], 32'hCAFE_F00D);
        step(1);

        // Out-of-window read, high address bits set
        t0 = cyc; issue(0, 32'hFFFF_0010, 1'b0, 4'h0, 32'h0); wait_done(0); drop(0);
        chk("oow_rd_err", 32'(last_err[0]), 32'h1);
        step(1);

        // Zero-mask write: SRAM selected, contents unchanged
        t0 = cyc; issue(0, 32'h20, 1'b1, 4'h0, 32'hFFFF_FFFF); wait_done(0); drop(0);
        chk("zmask_mem", mem[0][8], 32'h1000_0008);
        step(1);

        // Request inputs change after the latch, and req drops early
        t0 = cyc; issue(0, 32'h24, 1'b0, 4'h0, 32'h0);
        step(1);
        data_addr[0] = 32'h30; data_wr_en[0] = 1'b1; data_req[0] = 1'b0;
        step(3);
        chk("latch_rd", last_rd[0], 32'h1000_0009);
        chk("latch_ack_cyc", 32'(last_ack_cyc[0]), 32'(t0 + 3));
        step(1);

        // A few writes and readbacks across lanes
        for (int i = 0; i < 4; i++) begin
            issue(0, 32'h100 + 32'(4*i), 1'b1, 4'(1 << i), 32'h1122_3344 + 32'(i)); wait_done(0); drop(0);
            step(1);
            issue(0, 32'h100 + 32'(4*i), 1'b0, 4'h0, 32'h0); wait_done(0); drop(0);
            step(1);
        end

        // 6: reset in CAPTURE abandons the transaction
        a0 = ack_cnt[0];
        t0 = cyc; issue(0, 32'h14, 1'b0, 4'h0, 32'h0);
        step(2);
        #2;
        rstz[0] = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_ack",   32'(data_ack[0]), 32'h0);
        chk("t6_cs",    32'(sram_cs[0]),  32'h0);
        chk("t6_state", 32'(dbg_state[0]), 32'h0);
        drop(0);
        step(2);
        rstz[0] = 1'b1;
        step(2);
        chk("t6_no_ack", 32'(ack_cnt[0] - a0), 32'd0);
        t0 = cyc; issue(0, 32'h14, 1'b0, 4'h0, 32'h0); wait_done(0); drop(0);
        chk("t6_ack_cyc", 32'(last_ack_cyc[0]), 32'(t0 + 3));
        chk("t6_rd",      last_rd[0], 32'hDEAD_ABEF);

        step(3);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
